// File: rtl/cpu_pkg.sv
// Shared definitions for the data-processing execute sequencer: opcode and
// condition encodings, FSM state type, latched-instruction payload and the
// opcode classification helpers.
package cpu_pkg;

  localparam int unsigned COND_W = 4;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned NZCV_W = 4;

  localparam logic [REG_W-1:0] REG_PC = 4'd15;

  // Data-processing opcodes (ALU encoding)
  localparam logic [OPC_W-1:0] OPCODE_AND = 4'b0000;
  localparam logic [OPC_W-1:0] OPCODE_EOR = 4'b0001;
  localparam logic [OPC_W-1:0] OPCODE_SUB = 4'b0010;
  localparam logic [OPC_W-1:0] OPCODE_RSB = 4'b0011;
  localparam logic [OPC_W-1:0] OPCODE_ADD = 4'b0100;
  localparam logic [OPC_W-1:0] OPCODE_ADC = 4'b0101;
  localparam logic [OPC_W-1:0] OPCODE_SBC = 4'b0110;
  localparam logic [OPC_W-1:0] OPCODE_RSC = 4'b0111;
  localparam logic [OPC_W-1:0] OPCODE_TST = 4'b1000;
  localparam logic [OPC_W-1:0] OPCODE_TEQ = 4'b1001;
  localparam logic [OPC_W-1:0] OPCODE_CMP = 4'b1010;
  localparam logic [OPC_W-1:0] OPCODE_CMN = 4'b1011;
  localparam logic [OPC_W-1:0] OPCODE_ORR = 4'b1100;
  localparam logic [OPC_W-1:0] OPCODE_MOV = 4'b1101;
  localparam logic [OPC_W-1:0] OPCODE_BIC = 4'b1110;
  localparam logic [OPC_W-1:0] OPCODE_MVN = 4'b1111;

  // Condition field encodings
  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;
  localparam logic [COND_W-1:0] COND_NV = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_SKIP  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WB    = 3'd4
  } state_e;

  // Control fields of an accepted instruction (operands are latched separately)
  typedef struct packed {
    logic [COND_W-1:0] cond;
    logic [OPC_W-1:0]  opcode;
    logic              s_bit;
    logic [REG_W-1:0]  rd;
    logic              shifter_carry;
  } instr_ctl_t;

  // Logical ops take C from the shifter and leave V untouched
  function automatic logic is_logical(input logic [OPC_W-1:0] op);
    logic r;
    unique case (op)
      OPCODE_AND, OPCODE_EOR, OPCODE_TST, OPCODE_TEQ,
      OPCODE_ORR, OPCODE_MOV, OPCODE_BIC, OPCODE_MVN: r = 1'b1;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

  // TST/TEQ/CMP/CMN: flags only, no register write
  function automatic logic is_compare(input logic [OPC_W-1:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator.
// Ports:
//   cond_i    : 4-bit condition field
//   nzcv_i    : flags {N,Z,C,V}
//   pass_c_o  : 1 when the instruction should execute (combinational)
module cond_check
  import cpu_pkg::*;
(
  input  logic [COND_W-1:0] cond_i,
  input  logic [NZCV_W-1:0] nzcv_i,
  output logic              pass_c_o
);

  logic n, z, c, v;

  assign {n, z, c, v} = nzcv_i;

  always_comb begin
    pass_c_o = 1'b0;
    unique case (cond_i)
      COND_EQ: pass_c_o = z;
      COND_NE: pass_c_o = ~z;
      COND_CS: pass_c_o = c;
      COND_CC: pass_c_o = ~c;
      COND_MI: pass_c_o = n;
      COND_PL: pass_c_o = ~n;
      COND_VS: pass_c_o = v;
      COND_VC: pass_c_o = ~v;
      COND_HI: pass_c_o = c & ~z;
      COND_LS: pass_c_o = ~c | z;
      COND_GE: pass_c_o = (n == v);
      COND_LT: pass_c_o = (n != v);
      COND_GT: pass_c_o = ~z & (n == v);
      COND_LE: pass_c_o = z | (n != v);
      COND_AL: pass_c_o = 1'b1;
      COND_NV: pass_c_o = 1'b0;
      default: pass_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_exec_ctrl.sv
// Execute-stage sequencer for ARM data-processing instructions. Accepts one
// decoded instruction per handshake, evaluates its condition against the
// committed CPSR flags, drives the external ALU for one cycle, then writes
// the result back and commits NZCV. Owns the CPSR flag register.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   instr_valid / instr_ready   : decode handshake (ready only in IDLE)
//   cond, opcode, s_bit, rd,
//   op1, op2, shifter_carry     : decoded instruction fields
//   alu_*  (out)                : ALU enable, opcode, operands, carry-in, flag-update
//   alu_result, alu_n/z/c/v     : ALU outputs
//   rf_we, rf_waddr, rf_wdata   : register-file write port
//   cpsr_nzcv                   : committed {N,Z,C,V}
//   pc_flush                    : pulse when R15 is written
//   done                        : pulse when an instruction retires
module dp_exec_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [COND_W-1:0]     cond,
  input  logic [OPC_W-1:0]      opcode,
  input  logic                  s_bit,
  input  logic [REG_W-1:0]      rd,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic                  shifter_carry,
  output logic                  alu_enable,
  output logic [OPC_W-1:0]      alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_operand1,
  output logic [DATA_WIDTH-1:0] alu_operand2,
  output logic                  alu_carry_in,
  output logic                  alu_flag_update,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_n,
  input  logic                  alu_z,
  input  logic                  alu_c,
  input  logic                  alu_v,
  output logic                  rf_we,
  output logic [REG_W-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [NZCV_W-1:0]     cpsr_nzcv,
  output logic                  pc_flush,
  output logic                  done
);

  state_e                state_q, state_d;
  instr_ctl_t            ctl_q, ctl_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic [NZCV_W-1:0]     cpsr_q, cpsr_d;

  logic                  instr_ready_q, instr_ready_d;
  logic                  alu_enable_q, alu_enable_d;
  logic [OPC_W-1:0]      alu_opcode_q, alu_opcode_d;
  logic [DATA_WIDTH-1:0] alu_operand1_q, alu_operand1_d;
  logic [DATA_WIDTH-1:0] alu_operand2_q, alu_operand2_d;
  logic                  alu_carry_in_q, alu_carry_in_d;
  logic                  alu_flag_update_q, alu_flag_update_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_W-1:0]      rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  pc_flush_q, pc_flush_d;
  logic                  done_q, done_d;

  logic                  cond_pass_c;
  logic                  lat_logical_c;
  logic                  lat_compare_c;
  logic                  lat_flag_upd_c;

  // Condition is evaluated on the latched field against committed flags only
  cond_check u_cond_check (
    .cond_i   (ctl_q.cond),
    .nzcv_i   (cpsr_q),
    .pass_c_o (cond_pass_c)
  );

  assign lat_logical_c  = is_logical(ctl_q.opcode);
  assign lat_compare_c  = is_compare(ctl_q.opcode);
  assign lat_flag_upd_c = ctl_q.s_bit | lat_compare_c;

  // Next state and next registered outputs
  always_comb begin
    state_d           = state_q;
    ctl_d             = ctl_q;
    op1_d             = op1_q;
    op2_d             = op2_q;
    cpsr_d            = cpsr_q;
    instr_ready_d     = 1'b0;
    alu_enable_d      = 1'b0;
    alu_opcode_d      = '0;
    alu_operand1_d    = '0;
    alu_operand2_d    = '0;
    alu_carry_in_d    = 1'b0;
    alu_flag_update_d = 1'b0;
    rf_we_d           = 1'b0;
    rf_waddr_d        = rf_waddr_q;
    rf_wdata_d        = rf_wdata_q;
    pc_flush_d        = 1'b0;
    done_d            = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          ctl_d.cond          = cond;
          ctl_d.opcode        = opcode;
          ctl_d.s_bit         = s_bit;
          ctl_d.rd            = rd;
          ctl_d.shifter_carry = shifter_carry;
          op1_d               = op1;
          op2_d               = op2;
          state_d             = ST_CHECK;
        end else begin
          instr_ready_d = 1'b1;
        end
      end

      ST_CHECK: begin
        if (cond_pass_c) begin
          state_d           = ST_EXEC;
          alu_enable_d      = 1'b1;
          alu_opcode_d      = ctl_q.opcode;
          alu_operand1_d    = op1_q;
          alu_operand2_d    = op2_q;
          alu_carry_in_d    = lat_logical_c ? ctl_q.shifter_carry : cpsr_q[1];
          alu_flag_update_d = lat_flag_upd_c;
        end else begin
          state_d = ST_SKIP;
          done_d  = 1'b1;
        end
      end

      ST_SKIP: begin
        state_d       = ST_IDLE;
        instr_ready_d = 1'b1;
      end

      // ALU result is sampled here; write-back and flags appear in WB
      ST_EXEC: begin
        state_d    = ST_WB;
        done_d     = 1'b1;
        rf_we_d    = ~lat_compare_c;
        rf_waddr_d = ctl_q.rd;
        rf_wdata_d = alu_result;
        pc_flush_d = ~lat_compare_c & (ctl_q.rd == REG_PC);
        if (lat_flag_upd_c) begin
          cpsr_d = {alu_n, alu_z, alu_c, lat_logical_c ? cpsr_q[0] : alu_v};
        end
      end

      ST_WB: begin
        state_d       = ST_IDLE;
        instr_ready_d = 1'b1;
      end

      default: begin
        state_d       = ST_IDLE;
        instr_ready_d = 1'b1;
      end
    endcase
  end

  // State, latches and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      ctl_q             <= '0;
      op1_q             <= '0;
      op2_q             <= '0;
      cpsr_q            <= '0;
      instr_ready_q     <= 1'b1;
      alu_enable_q      <= 1'b0;
      alu_opcode_q      <= '0;
      alu_operand1_q    <= '0;
      alu_operand2_q    <= '0;
      alu_carry_in_q    <= 1'b0;
      alu_flag_update_q <= 1'b0;
      rf_we_q           <= 1'b0;
      rf_waddr_q        <= '0;
      rf_wdata_q        <= '0;
      pc_flush_q        <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      ctl_q             <= ctl_d;
      op1_q             <= op1_d;
      op2_q             <= op2_d;
      cpsr_q            <= cpsr_d;
      instr_ready_q     <= instr_ready_d;
      alu_enable_q      <= alu_enable_d;
      alu_opcode_q      <= alu_opcode_d;
      alu_operand1_q    <= alu_operand1_d;
      alu_operand2_q    <= alu_operand2_d;
      alu_carry_in_q    <= alu_carry_in_d;
      alu_flag_update_q <= alu_flag_update_d;
      rf_we_q           <= rf_we_d;
      rf_waddr_q        <= rf_waddr_d;
      rf_wdata_q        <= rf_wdata_d;
      pc_flush_q        <= pc_flush_d;
      done_q            <= done_d;
    end
  end

  assign instr_ready     = instr_ready_q;
  assign alu_enable      = alu_enable_q;
  assign alu_opcode      = alu_opcode_q;
  assign alu_operand1    = alu_operand1_q;
  assign alu_operand2    = alu_operand2_q;
  assign alu_carry_in    = alu_carry_in_q;
  assign alu_flag_update = alu_flag_update_q;
  assign rf_we           = rf_we_q;
  assign rf_waddr        = rf_waddr_q;
  assign rf_wdata        = rf_wdata_q;
  assign cpsr_nzcv       = cpsr_q;
  assign pc_flush        = pc_flush_q;
  assign done            = done_q;

endmodule

// File: tb/tb_dp_exec_ctrl.sv
// Bench for dp_exec_ctrl: behavioural ALU on the alu_* port, directed
// scenarios followed by randomized instructions checked against a
// flag/latency reference model.
module tb_dp_exec_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  cond;
  logic [3:0]  opcode;
  logic        s_bit;
  logic [3:0]  rd;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        shifter_carry;
  logic        alu_enable;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_operand1;
  logic [31:0] alu_operand2;
  logic        alu_carry_in;
  logic        alu_flag_update;
  logic [31:0] alu_result;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  cpsr_nzcv;
  logic        pc_flush;
  logic        done;

  int          n_cmp;
  int          n_bad;
  logic [3:0]  m_nzcv;

  dp_exec_ctrl #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .cond            (cond),
    .opcode          (opcode),
    .s_bit           (s_bit),
    .rd              (rd),
    .op1             (op1),
    .op2             (op2),
    .shifter_carry   (shifter_carry),
    .alu_enable      (alu_enable),
    .alu_opcode      (alu_opcode),
    .alu_operand1    (alu_operand1),
    .alu_operand2    (alu_operand2),
    .alu_carry_in    (alu_carry_in),
    .alu_flag_update (alu_flag_update),
    .alu_result      (alu_result),
    .alu_n           (alu_n),
    .alu_z           (alu_z),
    .alu_c           (alu_c),
    .alu_v           (alu_v),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .cpsr_nzcv       (cpsr_nzcv),
    .pc_flush        (pc_flush),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {N,Z,C,V,result}; logical ops pass carry_in through as C
  function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
    logic [31:0] x, y, r;
    logic [32:0] s;
    logic        ci, c, v, arith;
    arith = 1'b1; x = a; y = b; ci = 1'b0; r = '0;
    case (op)
      4'h0, 4'h8: begin r = a & b;  arith = 1'b0; end
      4'h1, 4'h9: begin r = a ^ b;  arith = 1'b0; end
      4'hC:       begin r = a | b;  arith = 1'b0; end
      4'hD:       begin r = b;      arith = 1'b0; end
      4'hE:       begin r = a & ~b; arith = 1'b0; end
      4'hF:       begin r = ~b;     arith = 1'b0; end
      4'h2, 4'hA: begin x = a; y = ~b; ci = 1'b1; end
      4'h3:       begin x = b; y = ~a; ci = 1'b1; end
      4'h4, 4'hB: begin x = a; y = b;  ci = 1'b0; end
      4'h5:       begin x = a; y = b;  ci = cin;  end
      4'h6:       begin x = a; y = ~b; ci = cin;  end
      default:    begin x = b; y = ~a; ci = cin;  end
    endcase
    if (arith) begin
      s = {1'b0, x} + {1'b0, y} + 33'(ci);
      r = s[31:0];
      c = s[32];
      v = (x[31] == y[31]) && (r[31] != x[31]);
    end else begin
      c = cin;
      v = 1'b0;
    end
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb begin
    {alu_n, alu_z, alu_c, alu_v, alu_result} =
      alu_ref(alu_opcode, alu_operand1, alu_operand2, alu_carry_in);
  end

  // Even/odd condition pairs: odd code is the inverse of the even one
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c >> 1)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: return (c == 4'hE);
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one instruction from an IDLE-cycle negedge; returns at the next IDLE negedge
  task automatic run_instr(input logic [3:0] c, input logic [3:0] op, input logic [3:0] r,
                           input logic s, input logic sc, input logic [31:0] a,
                           input logic [31:0] b, input bit hold);
    bit          pass, lg, cmpop, fu, wr, ex;
    logic        cin_e;
    logic [35:0] ar;
    int          lat;
    check_eq("idle_ready", 32'(instr_ready), 32'd1);
    check_eq("idle_nzcv", 32'(cpsr_nzcv), 32'(m_nzcv));
    cond = c; opcode = op; rd = r; s_bit = s; shifter_carry = sc; op1 = a; op2 = b;
    instr_valid = 1'b1;

    pass  = cond_ok(c, m_nzcv);
    lg    = (op inside {4'h0, 4'h1, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF});
    cmpop = (op >= 4'h8) && (op <= 4'hB);
    fu    = s || cmpop;
    wr    = !cmpop;
    cin_e = lg ? sc : m_nzcv[1];
    ar    = alu_ref(op, a, b, cin_e);
    lat   = pass ? 3 : 2;

    @(posedge clk);
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      ex = pass && (n == 2);
      check_eq("busy_ready", 32'(instr_ready), 32'd0);
      check_eq("done", 32'(done), 32'(n == lat));
      check_eq("alu_enable", 32'(alu_enable), 32'(ex));
      check_eq("rf_we", 32'(rf_we), 32'(pass && n == 3 && wr));
      check_eq("pc_flush", 32'(pc_flush), 32'(pass && n == 3 && wr && r == 4'd15));
      if (ex) begin
        check_eq("alu_opcode", 32'(alu_opcode), 32'(op));
        check_eq("alu_op1", alu_operand1, a);
        check_eq("alu_op2", alu_operand2, b);
        check_eq("alu_cin", 32'(alu_carry_in), 32'(cin_e));
        check_eq("alu_fupd", 32'(alu_flag_update), 32'(fu));
      end
      if (pass && n == 3 && wr) begin
        check_eq("rf_waddr", 32'(rf_waddr), 32'(r));
        check_eq("rf_wdata", rf_wdata, ar[31:0]);
      end
      if (hold && n < lat) begin
        instr_valid = 1'b1;
        cond = 4'($urandom); opcode = 4'($urandom); rd = 4'($urandom);
        s_bit = 1'($urandom); shifter_carry = 1'($urandom);
        op1 = $urandom; op2 = $urandom;
      end else begin
        instr_valid = 1'b0;
      end
    end
    if (pass && fu) m_nzcv = {ar[35:33], lg ? m_nzcv[0] : ar[32]};
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] t;
    case ($urandom_range(0, 4))
      0: t = 32'd0;
      1: t = 32'h7FFF_FFFF;
      2: t = 32'h8000_0000;
      3: t = 32'($urandom_range(0, 8));
      default: t = $urandom;
    endcase
    return t;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; m_nzcv = 4'b0000;
    rst_n = 1'b0; instr_valid = 1'b0;
    cond = '0; opcode = '0; rd = '0; s_bit = 1'b0; shifter_carry = 1'b0; op1 = '0; op2 = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(instr_ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rf_we", 32'(rf_we), 32'd0);
    check_eq("rst_alu_en", 32'(alu_enable), 32'd0);
    check_eq("rst_nzcv", 32'(cpsr_nzcv), 32'd0);
    check_eq("rst_flush", 32'(pc_flush), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADDS r1, 0x7FFFFFFF + 1 -> overflow into sign
    run_instr(4'hE, 4'h4, 4'd1, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    check_eq("t1_nzcv", 32'(cpsr_nzcv), 32'h9);
    // MOVS r0, #0 with shifter carry 1; V kept from previous
    run_instr(4'hE, 4'hD, 4'd0, 1'b1, 1'b1, 32'h1234, 32'd0, 1'b0);
    check_eq("t3_nzcv", 32'(cpsr_nzcv), 32'h7);
    // CMP 5,5 then MOVNE r2 (skipped)
    run_instr(4'hE, 4'hA, 4'd3, 1'b0, 1'b0, 32'd5, 32'd5, 1'b0);
    check_eq("t2_nzcv", 32'(cpsr_nzcv), 32'h6);
    run_instr(4'h1, 4'hD, 4'd2, 1'b0, 1'b0, 32'd0, 32'hAA, 1'b0);
    // SUB r15 without S: flush, flags unchanged
    run_instr(4'hE, 4'h2, 4'd15, 1'b0, 1'b0, 32'h100, 32'd4, 1'b0);
    check_eq("t4_nzcv", 32'(cpsr_nzcv), 32'h6);
    // NV with valid held throughout the busy period
    run_instr(4'hF, 4'h4, 4'd4, 1'b1, 1'b0, 32'd1, 32'd2, 1'b1);

    // Reset during EXEC of ADDS aborts it
    cond = 4'hE; opcode = 4'h4; rd = 4'd6; s_bit = 1'b1; op1 = 32'hFFFF_FFFF; op2 = 32'd1;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check_eq("t5_exec_en", 32'(alu_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_ready", 32'(instr_ready), 32'd1);
    check_eq("t5_nzcv", 32'(cpsr_nzcv), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq("t5_rf_we", 32'(rf_we), 32'd0);
      check_eq("t5_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    m_nzcv = 4'b0000;
    @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      run_instr(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                rnd_val(), rnd_val(), ($urandom_range(0, 3) == 0));
    end
    check_eq("final_nzcv", 32'(cpsr_nzcv), 32'(m_nzcv));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
